// File: rtl/scoreboard_decode.sv
// Register-busy scoreboard: one-hot decoded set/clear channels update a busy vector.
// Optional SCOREBOARD_DECODE_CLR_BYPASS_EN forwards same-cycle clears to rd_busy.
module scoreboard_decode #(
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned SET_PORTS = 2,
    parameter int unsigned CLR_PORTS = 2,
    parameter int unsigned RD_PORTS  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [SET_PORTS-1:0]           set_vld,
    input  logic [SET_PORTS*IDX_W-1:0]     set_idx,
    input  logic [CLR_PORTS-1:0]           clr_vld,
    input  logic [CLR_PORTS*IDX_W-1:0]     clr_idx,
    input  logic [RD_PORTS*IDX_W-1:0]      rd_idx,
    output logic [RD_PORTS-1:0]            rd_busy,
    output logic [ENTRIES-1:0]             busy_vec,
    output logic                           all_busy,
    output logic [IDX_W:0]                 busy_cnt
);

    logic [ENTRIES-1:0] set_mask;
    logic [ENTRIES-1:0] clr_mask;
    logic [ENTRIES-1:0] busy_next;
    logic [ENTRIES-1:0] rd_view;
    logic [IDX_W:0]     cnt_next;

    // Indices >= ENTRIES match no entry, so they decode to an all-zero mask.
    function automatic logic [ENTRIES-1:0] decode(input logic vld, input logic [IDX_W-1:0] idx);
        logic [ENTRIES-1:0] m;
        m = '0;
        for (int unsigned e = 0; e < ENTRIES; e++) begin
            m[e] = vld && (idx == IDX_W'(e));
        end
        return m;
    endfunction

    always_comb begin
        set_mask = '0;
        for (int unsigned k = 0; k < SET_PORTS; k++) begin
            set_mask = set_mask | decode(set_vld[k], set_idx[k*IDX_W +: IDX_W]);
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int unsigned k = 0; k < CLR_PORTS; k++) begin
            clr_mask = clr_mask | decode(clr_vld[k], clr_idx[k*IDX_W +: IDX_W]);
        end
    end

    // Set is OR'ed in after clear masking, so set wins on a same-cycle collision.
    always_comb begin
        if (flush) begin
            busy_next = '0;
        end else begin
            busy_next = (busy_vec & ~clr_mask) | set_mask;
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int unsigned e = 0; e < ENTRIES; e++) begin
            cnt_next = cnt_next + (IDX_W+1)'(busy_next[e]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
            busy_cnt <= '0;
            all_busy <= 1'b0;
        end else begin
            busy_vec <= busy_next;
            busy_cnt <= cnt_next;
            all_busy <= (cnt_next == (IDX_W+1)'(ENTRIES));
        end
    end

`ifdef SCOREBOARD_DECODE_CLR_BYPASS_EN
    assign rd_view = busy_vec & ~clr_mask;
`else
    assign rd_view = busy_vec;
`endif

    always_comb begin
        rd_busy = '0;
        for (int unsigned k = 0; k < RD_PORTS; k++) begin
            rd_busy[k] = |(decode(1'b1, rd_idx[k*IDX_W +: IDX_W]) & rd_view);
        end
    end

endmodule

// File: tb/tb_scoreboard_decode.sv
// Randomized bench for scoreboard_decode: a 64-entry and a 48-entry instance share
// stimulus and are checked against an array-based reference model.
module tb_scoreboard_decode;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  set_vld;
    logic [11:0] set_idx;
    logic [1:0]  clr_vld;
    logic [11:0] clr_idx;
    logic [23:0] rd_idx;

    logic [3:0]  rd_busy_a, rd_busy_b;
    logic [63:0] busy_vec_a;
    logic [47:0] busy_vec_b;
    logic [6:0]  busy_cnt_a, busy_cnt_b;
    logic        all_busy_a, all_busy_b;

    int unsigned tests;
    int unsigned errors;

    bit          mdl [2][64];
    int unsigned ents [2] = '{64, 48};

    scoreboard_decode #(.IDX_W(6), .ENTRIES(64), .SET_PORTS(2), .CLR_PORTS(2), .RD_PORTS(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .set_vld(set_vld), .set_idx(set_idx), .clr_vld(clr_vld), .clr_idx(clr_idx),
        .rd_idx(rd_idx), .rd_busy(rd_busy_a), .busy_vec(busy_vec_a),
        .all_busy(all_busy_a), .busy_cnt(busy_cnt_a)
    );

    scoreboard_decode #(.IDX_W(6), .ENTRIES(48), .SET_PORTS(2), .CLR_PORTS(2), .RD_PORTS(4)) dut48 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .set_vld(set_vld), .set_idx(set_idx), .clr_vld(clr_vld), .clr_idx(clr_idx),
        .rd_idx(rd_idx), .rd_busy(rd_busy_b), .busy_vec(busy_vec_b),
        .all_busy(all_busy_b), .busy_cnt(busy_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mvec(input int d);
        logic [63:0] v;
        v = '0;
        for (int e = 0; e < int'(ents[d]); e++) v[e] = mdl[d][e];
        return v;
    endfunction

    function automatic int mcnt(input int d);
        int c;
        c = 0;
        for (int e = 0; e < int'(ents[d]); e++) c += int'(mdl[d][e]);
        return c;
    endfunction

    function automatic bit cleared_now(input int d, input int q);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            logic [5:0] ci;
            ci = clr_idx[k*6 +: 6];
            if (clr_vld[k] && int'(ci) == q && q < int'(ents[d])) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic bit exp_rd(input int d, input int q);
        bit r;
        r = (q < int'(ents[d])) ? mdl[d][q] : 1'b0;
`ifdef SCOREBOARD_DECODE_CLR_BYPASS_EN
        if (cleared_now(d, q)) r = 1'b0;
`endif
        return r;
    endfunction

    // Clears are applied before sets, so a same-cycle set re-allocates the entry.
    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            if (flush) begin
                for (int e = 0; e < 64; e++) mdl[d][e] = 1'b0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    logic [5:0] ci;
                    ci = clr_idx[k*6 +: 6];
                    if (clr_vld[k] && int'(ci) < int'(ents[d])) mdl[d][ci] = 1'b0;
                end
                for (int k = 0; k < 2; k++) begin
                    logic [5:0] si;
                    si = set_idx[k*6 +: 6];
                    if (set_vld[k] && int'(si) < int'(ents[d])) mdl[d][si] = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 2; d++)
            for (int e = 0; e < 64; e++) mdl[d][e] = 1'b0;
    endfunction

    task automatic check_rd();
        for (int k = 0; k < 4; k++) begin
            logic [5:0] q;
            q = rd_idx[k*6 +: 6];
            check($sformatf("rd64[%0d] idx%0d", k, q), 64'(rd_busy_a[k]), 64'(exp_rd(0, int'(q))));
            check($sformatf("rd48[%0d] idx%0d", k, q), 64'(rd_busy_b[k]), 64'(exp_rd(1, int'(q))));
        end
    endtask

    task automatic check_state();
        check("vec64", busy_vec_a, mvec(0));
        check("cnt64", 64'(busy_cnt_a), 64'(mcnt(0)));
        check("all64", 64'(all_busy_a), 64'(mcnt(0) == 64));
        check("vec48", 64'(busy_vec_b), mvec(1));
        check("cnt48", 64'(busy_cnt_b), 64'(mcnt(1)));
        check("all48", 64'(all_busy_b), 64'(mcnt(1) == 48));
    endtask

    task automatic drive(input logic [1:0] sv, input int s0, input int s1,
                         input logic [1:0] cv, input int c0, input int c1, input logic fl);
        set_vld = sv;
        set_idx = {6'(s1), 6'(s0)};
        clr_vld = cv;
        clr_idx = {6'(c1), 6'(c0)};
        flush   = fl;
    endtask

    task automatic set_rd(input int q0, input int q1, input int q2, input int q3);
        rd_idx = {6'(q3), 6'(q2), 6'(q1), 6'(q0)};
    endtask

    // Inputs are driven 1 time unit after a rising edge; queries are checked mid-cycle.
    task automatic cycle();
        #2;
        check_rd();
        @(posedge clk);
        model_step();
        #1;
        check_state();
    endtask

    task automatic idle();
        drive(2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        model_clear();
        rst_n = 1'b0;
        idle();
        set_rd(0, 5, 63, 50);
        #12;
        check_state();
        check_rd();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 5; i++) cycle();
        check("idle_cnt_zero", 64'(busy_cnt_a), 64'd0);

        // dual set 5 and 63
        drive(2'b11, 5, 63, 2'b00, 0, 0, 1'b0);
        cycle();
        idle();
        cycle();
        check("dual_cnt", 64'(busy_cnt_a), 64'd2);
        check("dual_rd5", 64'(rd_busy_a[1]), 64'd1);

        // set/clear collision on 5, then clear alone
        drive(2'b01, 5, 0, 2'b01, 5, 0, 1'b0);
        cycle();
        check("collide_cnt", 64'(busy_cnt_a), 64'd2);
        drive(2'b00, 0, 0, 2'b01, 5, 0, 1'b0);
        cycle();
        check("clr_cnt", 64'(busy_cnt_a), 64'd1);

        // fill all entries, then flush with a concurrent set
        for (int c = 0; c < 32; c++) begin
            drive(2'b11, 2*c, 2*c+1, 2'b00, 0, 0, 1'b0);
            cycle();
        end
        check("fill_cnt", 64'(busy_cnt_a), 64'd64);
        check("fill_all", 64'(all_busy_a), 64'd1);
        drive(2'b01, 7, 0, 2'b00, 0, 0, 1'b1);
        cycle();
        check("flush_cnt", 64'(busy_cnt_a), 64'd0);
        check("flush_all", 64'(all_busy_a), 64'd0);

        // out of range for the 48-entry instance
        drive(2'b01, 50, 0, 2'b00, 0, 0, 1'b0);
        set_rd(50, 49, 47, 0);
        cycle();
        check("oor48_cnt", 64'(busy_cnt_b), 64'd0);
        check("oor48_rd50", 64'(rd_busy_b[0]), 64'd0);
        check("oor64_rd50", 64'(rd_busy_a[0]), 64'd1);

        // clear bypass on entry 9
        drive(2'b01, 9, 0, 2'b00, 0, 0, 1'b0);
        set_rd(9, 9, 9, 9);
        cycle();
        drive(2'b00, 0, 0, 2'b10, 0, 9, 1'b0);
        #2;
`ifdef SCOREBOARD_DECODE_CLR_BYPASS_EN
        check("bypass_rd9_N", 64'(rd_busy_a[0]), 64'd0);
`else
        check("bypass_rd9_N", 64'(rd_busy_a[0]), 64'd1);
`endif
        cycle();
        idle();
        #2;
        check("bypass_rd9_N1", 64'(rd_busy_a[0]), 64'd0);
        cycle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                  ($urandom_range(0, 59) == 0));
            if (($urandom & 1) == 1)
                set_rd(int'(set_idx[5:0]), int'(clr_idx[5:0]), int'(clr_idx[11:6]), int'($urandom_range(0, 63)));
            else
                set_rd(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                       int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            cycle();
        end

        // asynchronous reset mid-operation with traffic still applied
        drive(2'b11, 3, 4, 2'b01, 10, 0, 1'b0);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_state();
        check_rd();
        @(posedge clk);
        #1;
        check_state();
        rst_n = 1'b1;
        idle();
        cycle();
        check("post_reset_cnt", 64'(busy_cnt_a), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
